serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor computing a - b - bin, one bit per clock, LSB first.
- Built around a single full-subtractor cell and a registered borrow, the dual of the team's combinational full adder.
- Used in area-constrained datapaths where a ripple subtractor is too wide.
- Start/done handshake; results held until the next operation.

---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 100 ++++++++++
 tb/tb_serial_subtractor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - br_in, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic br_in,
    output logic d,
    output logic br_out
);

    assign d      = x ^ y ^ br_in;
    // Borrow when y exceeds x, or they are equal and a borrow ripples through.
    assign br_out = (~x & y) | (~(x ^ y) & br_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through a single
// full-subtractor cell; results are held until the next accepted start.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int                CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q, b_q, res_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               br_q;
    logic               a_msb_q, b_msb_q;
    logic               busy_q, done_q, bout_q, ovf_q;

    logic               d_bit, br_d;

    full_subtractor u_fs (
        .x      (a_q[0]),
        .y      (b_q[0]),
        .br_in  (br_q),
        .d      (d_bit),
        .br_out (br_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= {d_bit, res_q[WIDTH-1:1]};
                    br_q  <= br_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Last bit: d_bit is the result MSB, br_d the final borrow.
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bout_q  <= br_d;
                        ovf_q   <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = res_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: stimulus pushes expected results and timing, a monitor
// checks busy/done every cycle and the results whenever done is due.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           acc;
        int           done_at;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout, ovf;
    logic [W-1:0] diff;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   next_free = 0;
    exp_t q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for diff/bout, signed range for ovf.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        exp_t e;
        int   r, sr;
        r  = int'({24'd0, x}) - int'({24'd0, y}) - int'(bi);
        sr = int'($signed(x)) - int'($signed(y)) - int'(bi);
        e.diff = r[W-1:0];
        e.bout = (r < 0);
        e.ovf  = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
        e.acc = 0;
        e.done_at = 0;
        return e;
    endfunction

    // Monitor: sampled on the falling edge, cyc = index of last rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", {31'd0, busy}, 0);
            chk("rst_done", {31'd0, done}, 0);
            chk("rst_diff", {24'd0, diff}, 0);
            chk("rst_bout", {31'd0, bout}, 0);
            chk("rst_ovf",  {31'd0, ovf},  0);
        end else begin
            logic exp_busy, exp_done;
            exp_busy = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].done_at);
            exp_done = (q.size() > 0) && (cyc == q[0].done_at);
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("done", {31'd0, done}, {31'd0, exp_done});
            if (exp_done) begin
                chk("diff", {24'd0, diff}, {24'd0, q[0].diff});
                chk("bout", {31'd0, bout}, {31'd0, q[0].bout});
                chk("ovf",  {31'd0, ovf},  {31'd0, q[0].ovf});
                void'(q.pop_front());
            end
        end
    end

    // Issue one op at the first edge the block can accept it; optionally pulse
    // a junk start during RUN/DONE that must be ignored.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                         input bit junk, output int k);
        exp_t e;
        @(negedge clk);
        while (cyc + 1 < next_free) @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        k = cyc + 1;
        e = model(ta, tb_, tbin);
        e.acc = k;
        e.done_at = k + W;
        q.push_back(e);
        next_free = k + W + 2;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        if (junk) begin
            repeat ($urandom_range(0, W - 1)) @(negedge clk);
            a = 8'hFF; b = 8'h00; bin = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 4 * W) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int k;
        exp_t e;
        #3 rst_n = 1'b0;
        #1;
        chk("por_busy", {31'd0, busy}, 0);
        chk("por_diff", {24'd0, diff}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        next_free = cyc + 2;

        issue(8'h35, 8'h12, 1'b0, 1'b0, k);
        issue(8'h12, 8'h35, 1'b0, 1'b0, k);
        issue(8'h80, 8'h01, 1'b0, 1'b0, k);
        issue(8'h7F, 8'hFF, 1'b0, 1'b0, k);
        issue(8'h00, 8'h00, 1'b1, 1'b0, k);
        drain();

        // start held high: two accepts WIDTH+2 cycles apart
        @(negedge clk);
        while (cyc + 1 < next_free) @(negedge clk);
        a = 8'h00; b = 8'h00; bin = 1'b1; start = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            e = model(8'h00, 8'h00, 1'b1);
            e.acc = k + i * (W + 2);
            e.done_at = e.acc + W;
            q.push_back(e);
        end
        while (cyc < k + W + 2) @(negedge clk);
        start = 1'b0;
        next_free = k + 2 * (W + 2);
        drain();

        // junk start during RUN plus changing inputs must not disturb 0x35-0x12
        issue(8'h35, 8'h12, 1'b0, 1'b1, k);
        drain();

        // reset in RUN cycle 4: immediate zero outputs, no done
        issue(8'h35, 8'h12, 1'b0, 1'b0, k);
        while (cyc < k + 4) begin
            @(posedge clk);
            #1;
        end
        #1 rst_n = 1'b0;
        q.delete();
        #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_diff", {24'd0, diff}, 0);
        chk("abort_done", {31'd0, done}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        next_free = cyc + 2;
        repeat (W + 4) @(negedge clk);
        issue(8'h10, 8'h01, 1'b0, 1'b0, k);
        drain();

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), k);
        end
        drain();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
